mux_scan_ctrl: RTL



---
 rtl/mux_scan_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Sequences a 2**SEL_W : 1 bit mux. It steps sel through every channel,
//   waits DWELL settle cycles on each one, samples mux_out, and presents the
//   assembled word on scan_data together with a one-cycle valid pulse.
//
// Parameters
//   SEL_W  width of sel; channel count N_CH = 2**SEL_W
//   DWELL  settle cycles per channel before sampling (1..15, 0 is illegal)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      level request, sampled in IDLE (and in DONE with SCAN_CONT_EN)
//   mux_out    output bit of the mux being scanned
//   sel        channel select driven to the mux
//   scan_data  last completed scan, bit i = mux_out sampled with sel = i
//   valid      one-cycle pulse, scan_data has just been updated
//   busy       high while a scan is in progress (SETTLE / SAMPLE)
//
// Build option
//   SCAN_CONT_EN  when defined, start held in DONE begins the next scan
//                 directly, skipping the IDLE cycle between scans.
//
// state  | meaning
// IDLE   | waiting for start; sel holds its last value
// SETTLE | sel driven, counting DWELL settle cycles
// SAMPLE | capture mux_out into shadow[sel], then advance or finish
// DONE   | scan_data presented, valid high for this cycle only

module mux_scan_ctrl #(
  parameter int SEL_W = 2,
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mux_out,
  output logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] scan_data,
  output logic                  valid,
  output logic                  busy
);

  localparam int N_CH = 2**SEL_W;
  localparam logic [3:0]       DWELL_LAST = 4'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [SEL_W-1:0]  sel_n;
  logic [3:0]        cnt, cnt_n;
  logic [N_CH-1:0]   shadow, shadow_n;
  logic [N_CH-1:0]   scan_data_n;
  logic              valid_n;
  logic              busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      shadow    <= '0;
      scan_data <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      shadow    <= shadow_n;
      scan_data <= scan_data_n;
      valid     <= valid_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    cnt_n       = cnt;
    shadow_n    = shadow;
    scan_data_n = scan_data;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          sel_n   = '0;
          cnt_n   = '0;
        end
      end

      SETTLE: begin
        cnt_n = cnt + 4'd1;
        if (cnt == DWELL_LAST) begin
          state_n = SAMPLE;
        end
      end

      SAMPLE: begin
        shadow_n[sel] = mux_out;
        if (sel == SEL_LAST) begin
          // The word is loaded on the edge into DONE (last bit merged in)
          // so the registered scan_data is already new while valid is high.
          state_n     = DONE;
          scan_data_n = shadow_n;
        end else begin
          state_n = SETTLE;
          sel_n   = sel + 1'b1;
          cnt_n   = '0;
        end
      end

      DONE: begin
        state_n = IDLE;
`ifdef SCAN_CONT_EN
        if (start) begin
          state_n = SETTLE;
          sel_n   = '0;
          cnt_n   = '0;
        end
`endif
      end

      default: state_n = IDLE;
    endcase

    // Flags are registered from the next state so they line up with it.
    valid_n = (state_n == DONE);
    busy_n  = (state_n == SETTLE) || (state_n == SAMPLE);
  end

endmodule
